// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master: fetches sysid words 0/1, compares them with this build's expected values, reports pass/fail.
// Optional periodic re-check after a pass is compiled in when SYSID_CHK_PERIODIC_EN is defined.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1479909137,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned RETRY_MAX          = 3,
  parameter int unsigned PERIOD             = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [3:0]  retry_count
);

  if (READ_LATENCY > 7 || RETRY_MAX > 15 || PERIOD < 1) begin : g_bad_param
    $error("sysid_boot_checker: parameter out of range");
  end

  localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY);
  localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_GAP, RD_TS, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        match;
  logic        auto_start;

  assign match = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    retry_d = retry_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      IDLE, DONE: begin
        if (start || auto_start) begin
          state_d = RD_ID;
          wait_d  = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          retry_d = 4'd0;
        end
      end
      RD_ID: begin
        // The last cycle of the window is the one where the slave's data is valid.
        if (wait_q == LAST_WAIT) begin
          id_d    = sysid_readdata;
          wait_d  = 3'd0;
          state_d = RD_GAP;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      RD_GAP: state_d = RD_TS;
      RD_TS: begin
        if (wait_q == LAST_WAIT) begin
          ts_d    = sysid_readdata;
          wait_d  = 3'd0;
          state_d = CHECK;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      CHECK: begin
        if (match) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + 4'd1;
          state_d = RD_ID;
        end else begin
          pass_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes are registered from the next state so they change only on the clock edge.
    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      retry_q <= 4'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      retry_q <= retry_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
    end
  end

`ifdef SYSID_CHK_PERIODIC_EN
  localparam int PCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PCW-1:0] per_cnt_q;
  logic           per_arm_q;

  // Armed only by a passing check; any start (external or self) disarms until the next pass.
  always_ff @(posedge clock) begin
    if (reset) begin
      per_arm_q <= 1'b0;
      per_cnt_q <= '0;
    end else if (state_q == CHECK && state_d == DONE) begin
      per_arm_q <= match;
      per_cnt_q <= PCW'(PERIOD - 1);
    end else if (state_q == DONE && per_arm_q) begin
      if (start || auto_start) per_arm_q <= 1'b0;
      else                     per_cnt_q <= per_cnt_q - 1'b1;
    end
  end

  assign auto_start = per_arm_q && (state_q == DONE) && (per_cnt_q == '0);
`else
  assign auto_start = 1'b0;
`endif

  assign sysid_address = addr_q;
  assign sysid_read    = read_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign captured_id   = id_q;
  assign captured_ts   = ts_q;
  assign retry_count   = retry_q;

endmodule
